store_align_buffer: RTL and testbench

Store-side counterpart of the load path's sign/zero extension in the MIPS datapath: takes 32-bit register data from the MEM stage for SB/SH/SW and narrows it to the addressed byte lanes. It does this by replicating the data into the lanes and generating byte enables. Aligned stores are queued in a small FIFO and drained to data memory over a req/ack handshake. Misaligned stores are rejected with an address-error pulse.

---
 rtl/store_align_buffer_if.sv | 45 ++++
 rtl/store_align_buffer.sv | 140 ++++++++++++++
 tb/tb_store_align_buffer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/store_align_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_align_buffer_if
//  Brief    : Store-request and memory-drain signal bundle for the store
//             align buffer. The slave modport is the buffer itself; the
//             master modport is the MEM stage / memory side driving it.
//  Revision : 1.0  initial release
// ============================================================================
interface store_align_buffer_if #(
  parameter int DEPTH = 4
) ();

  // Store request side
  logic                     st_valid;
  logic                     st_ready;
  logic [31:0]              st_addr;
  logic [31:0]              st_data;
  logic [1:0]               st_size;

  // Memory drain side
  logic                     mem_req;
  logic                     mem_ack;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_be;

  // Status
  logic                     misalign;
  logic [31:0]              misalign_addr;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           misalign, misalign_addr, count
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           misalign, misalign_addr, count
  );

endinterface
`default_nettype wire

// File: rtl/store_align_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_align_buffer
//  Brief    : Packs SB/SH/SW register data into replicated byte lanes with
//             byte enables, rejects misaligned stores with a one-cycle pulse,
//             and queues aligned stores in a FIFO drained over req/ack.
//  Revision : 1.0  initial release
// ============================================================================
module store_align_buffer #(
  parameter int DEPTH = 4
) (
  input  wire logic            clk,
  input  wire logic            reset,
  store_align_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     misalign_addr_q, misalign_addr_d;

  entry_t          entry_d;
  entry_t          head;
  logic            legal;
  logic            st_ready_w;
  logic            accept;
  logic            push;
  logic            pop;
  logic            not_empty;

  // Lane packing and alignment check for the incoming store.
  always_comb begin
    entry_d       = '0;
    legal         = 1'b0;
    entry_d.waddr = bus.st_addr[31:2];
    case (bus.st_size)
      SIZE_BYTE: begin
        legal         = 1'b1;
        entry_d.wdata = {4{bus.st_data[7:0]}};
        entry_d.be    = 4'b0001 << bus.st_addr[1:0];
      end
      SIZE_HALF: begin
        legal         = ~bus.st_addr[0];
        entry_d.wdata = {2{bus.st_data[15:0]}};
        entry_d.be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        legal         = (bus.st_addr[1:0] == 2'b00);
        entry_d.wdata = bus.st_data;
        entry_d.be    = 4'b1111;
      end
      default: begin
        legal         = 1'b0;
      end
    endcase
  end

  // Handshake decode and next-state for pointers, occupancy and error flag.
  always_comb begin
    not_empty  = (count_q != '0);
    st_ready_w = (count_q < FULL_COUNT);
    accept     = bus.st_valid && st_ready_w;
    push       = accept && legal;
    pop        = not_empty && bus.mem_ack;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    misalign_d      = accept && !legal;
    misalign_addr_d = misalign_d ? bus.st_addr : misalign_addr_q;
  end

  // Control state; reset discards queued entries and any concurrent event.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Entry storage; contents are don't-care while unoccupied since the
  // outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_q[wr_ptr_q] <= entry_d;
    end
  end

  // Head presentation, forced to zero when nothing is queued.
  always_comb begin
    head = fifo_q[rd_ptr_q];
    if (!not_empty) head = '0;
  end

  assign bus.st_ready      = st_ready_w;
  assign bus.mem_req       = not_empty;
  assign bus.mem_addr      = {head.waddr, 2'b00};
  assign bus.mem_wdata     = head.wdata;
  assign bus.mem_be        = head.be;
  assign bus.misalign      = misalign_q;
  assign bus.misalign_addr = misalign_addr_q;
  assign bus.count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_store_align_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_align_buffer
//  Brief    : Self-checking bench for store_align_buffer against a queue-based
//             behavioural model; directed scenarios followed by random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_align_buffer;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  store_align_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_align_buffer #(.DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        model_q[$];
  logic        exp_mis;
  logic [31:0] exp_mis_addr;
  int          n_cmp;
  int          n_err;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference packing from the store rules, using plain arithmetic.
  function automatic void model_pack(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] sz, output bit legal, output exp_t e);
    e.addr  = a & 32'hFFFF_FFFC;
    e.wdata = 32'h0;
    e.be    = 4'h0;
    legal   = 1'b0;
    case (sz)
      2'd0: begin
        legal   = 1'b1;
        e.wdata = (d & 32'hFF) * 32'h0101_0101;
        e.be    = 4'(1 << (a % 4));
      end
      2'd1: begin
        legal   = (a % 2 == 0);
        e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        e.be    = ((a & 32'h2) != 0) ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        legal   = (a % 4 == 0);
        e.wdata = d;
        e.be    = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("count", 32'(bus.count), 32'(model_q.size()));
    chk("mem_req", 32'(bus.mem_req), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      chk("mem_addr", bus.mem_addr, model_q[0].addr);
      chk("mem_wdata", bus.mem_wdata, model_q[0].wdata);
      chk("mem_be", 32'(bus.mem_be), 32'(model_q[0].be));
    end else begin
      chk("mem_addr_empty", bus.mem_addr, 32'h0);
      chk("mem_wdata_empty", bus.mem_wdata, 32'h0);
      chk("mem_be_empty", 32'(bus.mem_be), 32'h0);
    end
    chk("misalign", 32'(bus.misalign), 32'(exp_mis));
    chk("misalign_addr", bus.misalign_addr, exp_mis_addr);
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit ack);
    bit   acc, legal, pop;
    exp_t e;
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = sz;
    bus.mem_ack  = ack;
    #1;
    chk("st_ready", 32'(bus.st_ready), 32'(model_q.size() < DEPTH));
    acc = v && (model_q.size() < DEPTH);
    pop = (model_q.size() != 0) && ack;
    model_pack(a, d, sz, legal, e);
    if (pop) void'(model_q.pop_front());
    if (acc && legal) model_q.push_back(e);
    exp_mis = acc && !legal;
    if (exp_mis) exp_mis_addr = a;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit ack);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, ack);
  endtask

  // Reset with a possibly active store and ack; reset must win.
  task automatic do_reset(input bit ack);
    reset        = 1'b1;
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h0000_4000;
    bus.st_data  = 32'h1111_2222;
    bus.st_size  = 2'b10;
    bus.mem_ack  = ack;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.st_valid = 1'b0;
    model_q.delete();
    exp_mis      = 1'b0;
    exp_mis_addr = 32'h0;
    check_outputs();
    chk("st_ready_after_reset", 32'(bus.st_ready), 32'h1);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    exp_mis      = 1'b0;
    exp_mis_addr = 32'h0;
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_addr  = 32'h0;
    bus.st_data  = 32'h0;
    bus.st_size  = 2'b00;
    bus.mem_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Byte store into lane 3, then drain.
    cycle(1'b1, 32'h0000_1003, 32'hAABB_CC7F, 2'b00, 1'b0);
    chk("sb_be_lane3", 32'(bus.mem_be), 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'h7F7F_7F7F);
    idle(1'b1);
    chk("sb_drained_be", 32'(bus.mem_be), 32'h0);

    // Halfword then word, presented in order.
    cycle(1'b1, 32'h0000_2002, 32'h1234_5678, 2'b01, 1'b0);
    chk("sh_wdata", bus.mem_wdata, 32'h5678_5678);
    cycle(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 2'b10, 1'b0);
    idle(1'b1);
    chk("sw_be", 32'(bus.mem_be), 32'hF);
    idle(1'b1);

    // Three back-to-back rejected stores.
    cycle(1'b1, 32'h0000_3001, 32'h0, 2'b01, 1'b0);
    chk("mis_addr_1", bus.misalign_addr, 32'h0000_3001);
    cycle(1'b1, 32'h0000_3006, 32'h0, 2'b10, 1'b0);
    cycle(1'b1, 32'h0000_3008, 32'h0, 2'b11, 1'b0);
    chk("mis_addr_3", bus.misalign_addr, 32'h0000_3008);
    idle(1'b0);

    // Fill to full with ack low, fifth stalls, then drain with wrap.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h0000_5000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 2'b10, 1'b0);
    chk("full_ready_low", 32'(bus.st_ready), 32'h0);
    cycle(1'b1, 32'h0000_5010, 32'hC0DE_0004, 2'b10, 1'b1);
    cycle(1'b1, 32'h0000_5010, 32'hC0DE_0004, 2'b10, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Sustained one-in/one-out streaming.
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 32'h0000_6000 + 32'(i), 32'(i * 32'h0101_0101), 2'b00, 1'b1);
    chk("stream_count", 32'(bus.count), 32'h1);
    idle(1'b1);

    // Reset with three entries queued and ack asserted.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h0000_7000 + 32'(i * 4), 32'h7777_0000 + 32'(i), 2'b10, 1'b0);
    do_reset(1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
